// File: rtl/vld_tap_delay_pkg.sv
// -----------------------------------------------------------------------------
// vld_tap_delay_pkg
//   Shared definitions for the selectable-tap valid delay line.
//   - Default geometry of the delay line.
//   - vld_clog2 : constant-foldable ceil(log2(n)), used to size the
//                 delay-select and fill-count fields.
//   - vld_clamp : limits a requested delay to the physical chain depth.
// -----------------------------------------------------------------------------
package vld_tap_delay_pkg;

    localparam int VLD_DEF_WIDTH     = 8;
    localparam int VLD_DEF_MAX_DEPTH = 32;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int vld_clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // min(dly, max_depth)
    function automatic int unsigned vld_clamp(input int unsigned dly,
                                              input int unsigned max_depth);
        return (dly > max_depth) ? max_depth : dly;
    endfunction

endpackage : vld_tap_delay_pkg

// File: rtl/vld_tap_delay_mux.sv
// -----------------------------------------------------------------------------
// vld_tap_delay_mux
//   Combinational tap selector for the delay chain.
//   sel_i = 0       -> bypass_i
//   sel_i = N       -> stage N-1 of the flattened chain (1 <= N <= DEPTH)
//   sel_i > DEPTH   -> bypass_i; the parent clamps the select, so this
//                      branch is unreachable in normal use.
//
// Ports
//   stages_i  in   W*DEPTH  flattened chain, stage k at [k*W +: W]
//   sel_i     in   SELW     tap select
//   bypass_i  in   W        word returned for sel_i = 0
//   tap_o     out  W        selected word
// -----------------------------------------------------------------------------
module vld_tap_delay_mux
    import vld_tap_delay_pkg::*;
#(
    parameter  int W     = VLD_DEF_WIDTH + 1,
    parameter  int DEPTH = VLD_DEF_MAX_DEPTH,
    localparam int SELW  = vld_clog2(DEPTH + 1)
) (
    input  logic [W*DEPTH-1:0] stages_i,
    input  logic [SELW-1:0]    sel_i,
    input  logic [W-1:0]       bypass_i,
    output logic [W-1:0]       tap_o
);

    always_comb begin
        tap_o = bypass_i;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_i == SELW'(i + 1)) begin
                tap_o = stages_i[i*W +: W];
            end
        end
    end

endmodule : vld_tap_delay_mux

// File: rtl/vld_tap_delay.sv
// -----------------------------------------------------------------------------
// vld_tap_delay
//   Run-time selectable delay line for a WIDTH-bit word plus its valid flag.
//   The chain advances only on enabled cycles, so latency is counted in
//   enabled shifts rather than clocks. A fill counter tracks how many shifts
//   have occurred since the last reset, flush or delay change; the output
//   valid is suppressed until enough fresh shifts have filled the selected
//   tap, so no word captured under an older configuration is flagged valid.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      synchronous reset, active low
//   en        in   1      shift enable
//   flush     in   1      clear all valids and the fill count (beats en)
//   dly       in   DW     requested delay, clamped to MAX_DEPTH
//   din       in   WIDTH  input word
//   din_vld   in   1      input valid
//   dout      out  WIDTH  word from the selected tap (din when dly = 0)
//   dout_vld  out  1      tap valid qualified by primed
//   primed    out  1      enough enabled shifts since the last clear event
//
// Parameters
//   RESET_DATA = 0 leaves the data stages without reset so they can map onto
//   shift-register primitives; only the valid chain is cleared.
// -----------------------------------------------------------------------------
module vld_tap_delay
    import vld_tap_delay_pkg::*;
#(
    parameter  int WIDTH      = VLD_DEF_WIDTH,
    parameter  int MAX_DEPTH  = VLD_DEF_MAX_DEPTH,
    parameter  int RESET_DATA = 0,
    localparam int DW         = vld_clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [DW-1:0]    dly,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             primed
);

    localparam int            SW      = WIDTH + 1;
    localparam logic [DW-1:0] MAX_DLY = DW'(MAX_DEPTH);

    logic [WIDTH-1:0]        data_q [MAX_DEPTH];
    logic [MAX_DEPTH-1:0]    vld_q;
    logic [MAX_DEPTH-1:0]    vld_d;
    logic [DW-1:0]           fill_q;
    logic [DW-1:0]           fill_d;
    logic [DW-1:0]           dly_q;
    logic [DW-1:0]           dly_c;
    logic                    shift;
    logic                    dly_chg;
    logic [SW*MAX_DEPTH-1:0] stages_flat;
    logic [SW-1:0]           tap;

    // flush wins over en: nothing is captured in a flush cycle.
    assign shift   = en & ~flush;
    assign dly_chg = (dly != dly_q);
    assign dly_c   = DW'(vld_clamp(32'(dly), MAX_DEPTH));

    // ------------------------------------------------------------------
    // Valid chain
    // ------------------------------------------------------------------
    always_comb begin
        vld_d = vld_q;
        if (flush) begin
            vld_d = '0;
        end else if (en) begin
            vld_d[0] = din_vld;
            for (int i = 1; i < MAX_DEPTH; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Data chain
    // ------------------------------------------------------------------
    if (RESET_DATA != 0) begin : g_data_rst
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < MAX_DEPTH; i++) begin
                    data_q[i] <= '0;
                end
            end else if (shift) begin
                data_q[0] <= din;
                for (int i = 1; i < MAX_DEPTH; i++) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end else begin : g_data_nrst
        // No reset term so the chain stays a plain enabled shift register.
        always_ff @(posedge clk) begin
            if (shift) begin
                data_q[0] <= din;
                for (int i = 1; i < MAX_DEPTH; i++) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Fill counter and registered delay
    // ------------------------------------------------------------------
    // On a delay change the count restarts, but the shift happening in that
    // same cycle already belongs to the new configuration: its word is the
    // first one that may later be presented as valid, so it is counted.
    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            fill_d = '0;
        end else if (dly_chg) begin
            fill_d = en ? DW'(1) : '0;
        end else if (en && (fill_q < MAX_DLY)) begin
            fill_d = fill_q + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_q <= '0;
            dly_q  <= '0;
        end else begin
            fill_q <= fill_d;
            dly_q  <= dly;
        end
    end

    // ------------------------------------------------------------------
    // Tap selection and output qualification
    // ------------------------------------------------------------------
    for (genvar g = 0; g < MAX_DEPTH; g++) begin : g_flat
        assign stages_flat[g*SW +: SW] = {vld_q[g], data_q[g]};
    end

    vld_tap_delay_mux #(
        .W     (SW),
        .DEPTH (MAX_DEPTH)
    ) u_tap_mux (
        .stages_i (stages_flat),
        .sel_i    (dly_c),
        .bypass_i ({din_vld, din}),
        .tap_o    (tap)
    );

    // In the cycle a new delay is presented, fill_q still reflects the old
    // configuration, so primed is held low until the register catches up.
    always_comb begin
        primed = 1'b1;
        if (dly_c != '0) begin
            primed = !dly_chg && (fill_q >= dly_c);
        end
    end

    assign dout     = tap[WIDTH-1:0];
    assign dout_vld = tap[SW-1] & primed;

endmodule : vld_tap_delay
